// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtract mode: SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell used by the serial adder.
// Purely combinational; the carry is registered by the caller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN for the sub/overflow ports.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             overflow,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q;
  logic             cout_q;
  logic             out_valid_q;
  logic             fa_b;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH:0]   shift_d;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  logic ovf_q;
  assign fa_b     = b_q[0] ^ sub_q;
  assign overflow = ovf_q;
`else
  assign fa_b = b_q[0];
`endif

  full_adder u_fa (
    .a   (a_q[0]),
    .b   (fa_b),
    .cin (c_q),
    .sum (fa_s),
    .cout(fa_c)
  );

  // New bit enters at the MSB; after WIDTH shifts it lands at bit 0.
  assign shift_d = {fa_s, res_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            state_q <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub;
            c_q     <= sub | cin;
`else
            c_q     <= cin;
`endif
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= shift_d[WIDTH:1];
          c_q   <= fa_c;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= fa_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q       <= c_q ^ fa_c;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = res_q;
  assign cout      = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder that sums two WIDTH-bit operands plus a carry-in, one bit per clock, through a single registered `full_adder` cell. It trades latency for area. It replaces a flat combinational adder wherever wide operands arrive infrequently. Operands enter and results leave over valid/ready handshakes, so the block drops into streaming datapaths with back-pressure.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  result held on `sum`/`cout`.
- `out_ready`  in  1  downstream accepts result.
- `sum`  out  WIDTH  registered result.
- `cout`  out  1  registered carry-out.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values:
  - `out_valid`=0, `sum`=0, `cout`=0.
  - Bit counter and shift registers cleared.
  - `in_ready`=1 once reset is released, because it decodes directly from IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `a`, `b` and `cin` into the A/B shift registers and the carry register.
  - Clear the counter, then go to RUN.
  - Inputs are not sampled at any other time.
- RUN, each cycle:
  - `full_adder` takes A[0], B[0] and the carry register.
  - Its sum bit shifts into the result register at the MSB end; A and B shift right.
  - The carry register takes the cell's carry-out.
  - The counter increments.
  - After the WIDTH-th RUN cycle, `sum` holds the full result, `cout` holds the final carry, and the FSM goes to DONE.
- DONE:
  - `out_valid`=1; `sum`/`cout` are held stable.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `in_ready` stays low in DONE, so there is no overlap with the next operand set.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1).
- Counter width: $clog2(WIDTH+1).
- Reset mid-operation: asserting `rst_n` in RUN or DONE aborts immediately. The pending result is discarded and never presented.

## Timing
- Accept edge is E0. RUN edges are E1..E_WIDTH.
- `out_valid` rises after E_WIDTH, giving a latency of WIDTH cycles from accept to `out_valid`.
- Output handshake edge: `out_valid` falls after it and `in_ready` rises after it.
- Minimum spacing between accepts is WIDTH+2 cycles, reached when `out_ready` is held high.
- `out_ready` held low keeps `out_valid`, `sum` and `cout` constant indefinitely.
- `in_ready` is a function of state only; it has no combinational path from `in_valid`.

## Configuration
- `SERIAL_ADDER_SUB_EN` adds two ports: input `sub` (1 bit) and output `overflow` (1 bit).
- Behaviour with the macro defined:
  - `sub` is latched at accept alongside the operands.
  - When `sub`=1, B bits are inverted into the cell and the carry register is loaded with 1 (`cin` ignored). The result is `a` − `b`, and `cout`=1 means no borrow.
  - `overflow` = carry into the MSB XOR final carry, i.e. two's-complement overflow. It is valid with `out_valid` and resets to 0.
- Without the macro:
  - Neither port exists.
  - Behaviour is pure addition as described above.

## Structure
- `serial_adder_pkg` holds:
  - the FSM state typedef (IDLE/RUN/DONE);
  - the default WIDTH constant;
  - a function computing the counter width.
- Sub-module: one instance of the existing `full_adder` (ports `a`, `b`, `cin`, `sum`, `cout`) as the bit cell.
- All sequencing lives in `serial_adder`.

## Test plan
All scenarios use WIDTH=8.
- 0x00 + 0x00, `cin`=0 -> `sum`=0x00, `cout`=0; `out_valid` rises exactly 8 cycles after the accept edge.
- 0xFF + 0x01, `cin`=0 -> `sum`=0x00, `cout`=1. Then 0xA5 + 0x5A, `cin`=1 -> `sum`=0x00, `cout`=1.
- Back-pressure: `out_ready` low for 5 cycles after `out_valid` -> `sum`/`cout` stable and `in_ready`=0 throughout. `in_valid` with new operands in that window is ignored.
- Reset mid-RUN: `rst_n` low at the 3rd RUN cycle -> `out_valid`=0, `sum`=0 and `in_ready`=1 after release; no result is emitted.
- Back-to-back operations with `in_valid` and `out_ready` held high -> accepts exactly 10 cycles apart, and each result matches a+b+cin.
- With `SERIAL_ADDER_SUB_EN`:
  - 0x05 − 0x07 -> `sum`=0xFE, `cout`=0, `overflow`=0.
  - 0x80 − 0x01 -> `sum`=0x7F, `cout`=1, `overflow`=1.
